// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the RISC-V multi-cycle control path.
// Holds the sequencer state encoding, the base opcode values the sequencer
// recognises, and the default reset PC.
package riscv_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational classification of a 32-bit instruction word by its major
// opcode (bits [6:0]).
// Ports:
//   instruction_word : instruction to classify
//   legal            : opcode is one of the supported base opcodes
//   is_system        : opcode is SYSTEM (ECALL/EBREAK)
//   writes_rd        : opcode architecturally writes rd (rd==0 not filtered here)
module opcode_classifier
  import riscv_ctrl_pkg::*;
(
  input  logic [31:0] instruction_word,
  output logic        legal,
  output logic        is_system,
  output logic        writes_rd
);

  // Only the opcode field matters here; the rest is reduced into a sink so
  // the unused upper bits are visibly intentional.
  logic unused_fields;
  assign unused_fields = ^instruction_word[31:7];

  always_comb begin
    // NOTE: every output gets a default before the case so that opcodes not
    // listed below cannot leave an output unassigned and infer a latch.
    legal     = 1'b0;
    is_system = 1'b0;
    writes_rd = 1'b0;
    case (instruction_word[6:0])
      OP_R, OP_IMM, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: begin
        legal     = 1'b1;
        writes_rd = 1'b1;
      end
      OP_STORE, OP_BRANCH: begin
        legal = 1'b1;
      end
      OP_SYSTEM: begin
        legal     = 1'b1;
        is_system = 1'b1;
        writes_rd = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer for the RISC-V DataPath.
// Fetches an instruction over a req/ready + rvalid handshake, holds it on
// instruction_word, and walks it through DECODE, EXEC and WB. Owns the PC,
// applies branch redirects sampled in EXEC, and halts on SYSTEM, illegal
// opcodes or misaligned branch targets.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   run                 : level, permits a new fetch
//   imem_req/imem_addr  : fetch request and address (addr == pc)
//   imem_ready          : request accepted
//   imem_rvalid/rdata   : read response
//   instruction_word    : latched instruction into the datapath
//   branch_taken/target : redirect from the datapath, sampled in EXEC
//   reg_we              : register-file write enable pulse in WB
//   pc                  : current program counter
//   retired             : pulse per completed instruction
//   retire_count        : wrapping count of retired instructions
//   halted, illegal     : sticky halt status and illegal-cause flag
module instr_sequencer
  import riscv_ctrl_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instruction_word,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            reg_we,
  output logic [XLEN-1:0] pc,
  output logic            retired,
  output logic [31:0]     retire_count,
  output logic            halted,
  output logic            illegal
);

  state_t            state, state_nxt;
  logic [31:0]       instr_q;
  logic [XLEN-1:0]   pc_q;
  logic              taken_q;
  logic [XLEN-1:0]   target_q;
  logic              illegal_q;
  logic [31:0]       retire_count_q;

  logic              legal;
  logic              is_system;
  logic              writes_rd;
  logic              misaligned_redirect;

  opcode_classifier u_classifier (
    .instruction_word (instr_q),
    .legal            (legal),
    .is_system        (is_system),
    .writes_rd        (writes_rd)
  );

  assign misaligned_redirect = branch_taken && (branch_target[1:0] != 2'b00);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (run) state_nxt = S_FETCH;
      S_FETCH:  if (imem_ready) state_nxt = S_WAIT;
      // Responses are only honoured here, so stale rvalid after a reset or
      // during FETCH can never corrupt the latched word.
      S_WAIT:   if (imem_rvalid) state_nxt = S_DECODE;
      S_DECODE: begin
        if (!legal || is_system) state_nxt = S_HALT;
        else                     state_nxt = S_EXEC;
      end
      S_EXEC:   state_nxt = misaligned_redirect ? S_HALT : S_WB;
      S_WB:     state_nxt = run ? S_FETCH : S_IDLE;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order or process order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q        <= '0;
      pc_q           <= RESET_PC;
      taken_q        <= 1'b0;
      target_q       <= '0;
      illegal_q      <= 1'b0;
      retire_count_q <= '0;
    end else begin
      case (state)
        S_WAIT: if (imem_rvalid) instr_q <= imem_rdata;
        S_DECODE: if (!legal) illegal_q <= 1'b1;
        S_EXEC: begin
          taken_q  <= branch_taken;
          target_q <= branch_target;
          if (misaligned_redirect) illegal_q <= 1'b1;
        end
        S_WB: begin
          // Plain add wraps modulo 2^XLEN, so the top word rolls over to 0.
          pc_q           <= taken_q ? target_q : pc_q + XLEN'(4);
          retire_count_q <= retire_count_q + 32'd1;
        end
        default: ;
      endcase
    end
  end

  // All outputs come from registers or the state register alone.
  assign imem_req         = (state == S_FETCH);
  assign imem_addr        = pc_q;
  assign pc               = pc_q;
  assign instruction_word = instr_q;
  assign reg_we           = (state == S_WB) && writes_rd && (instr_q[11:7] != 5'd0);
  assign retired          = (state == S_WB);
  assign retire_count     = retire_count_q;
  assign halted           = (state == S_HALT);
  assign illegal          = illegal_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: hand-written sequences for multi-cycle
// corner cases followed by a table of single-instruction vectors. A second
// instance with RESET_PC at the top word shares the stimulus to exercise
// PC wrap-around.
module tb_instr_sequencer;
  import riscv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        branch_taken;
  logic [31:0] branch_target;

  logic        imem_req, reg_we, retired, halted, illegal;
  logic [31:0] imem_addr, instruction_word, pc, retire_count;

  logic        w_imem_req, w_reg_we, w_retired, w_halted, w_illegal;
  logic [31:0] w_imem_addr, w_instruction_word, w_pc, w_retire_count;

  instr_sequencer #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instruction_word(instruction_word),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .reg_we(reg_we), .pc(pc), .retired(retired), .retire_count(retire_count),
    .halted(halted), .illegal(illegal)
  );

  instr_sequencer #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instruction_word(w_instruction_word),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .reg_we(w_reg_we), .pc(w_pc), .retired(w_retired), .retire_count(w_retire_count),
    .halted(w_halted), .illegal(w_illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int ret_pulses = 0;
  int we_pulses = 0;
  int tests = 0;
  int fails = 0;

  always @(posedge clk) begin
    cyc++;
    if (retired) ret_pulses++;
    if (reg_we) we_pulses++;
  end

  typedef struct {
    string       name;
    logic [31:0] word;
    logic        taken;
    logic [31:0] target;
    logic        exp_we;
    logic        exp_halt;
    logic        exp_ill;
    logic [31:0] exp_pc;
    logic [31:0] exp_wpc;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    run           = 1'b0;
    imem_ready    = 1'b0;
    imem_rvalid   = 1'b0;
    imem_rdata    = '0;
    branch_taken  = 1'b0;
    branch_target = '0;
    step();
    step();
    rst = 1'b1;
    step();
    ret_pulses = 0;
    we_pulses  = 0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) check("req_timeout", 32'd0, 32'd1);
  endtask

  // Serves one fetch; returns at the DECODE-cycle negedge with the number of
  // cycles stepped since the FETCH cycle was first observed.
  task automatic serve(input string tag, input logic [31:0] word, input int rdy_dly,
                       input int rv_dly, input logic [31:0] exp_addr, output int steps);
    bit ok;
    logic [31:0] a0, w0;
    steps = 0;
    wait_req(ok);
    check({tag, "_addr"}, imem_addr, exp_addr);
    a0 = imem_addr;
    w0 = instruction_word;
    for (int i = 0; i < rdy_dly; i++) begin
      imem_ready  = 1'b0;
      imem_rvalid = 1'b1;          // stray response while still in FETCH
      imem_rdata  = 32'hBAD0_BAD0;
      step();
      steps++;
      check({tag, "_req_held"}, imem_req, 32'd1);
      check({tag, "_addr_held"}, imem_addr, a0);
    end
    imem_rvalid = 1'b0;
    imem_ready  = 1'b1;
    step();
    steps++;
    imem_ready = 1'b0;
    for (int i = 0; i < rv_dly; i++) begin
      check({tag, "_word_hold"}, instruction_word, w0);
      step();
      steps++;
    end
    check({tag, "_word_pre"}, instruction_word, w0);
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    step();
    steps++;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    check({tag, "_word"}, instruction_word, word);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!(retired || halted) && n < 12) begin
      step();
      n++;
    end
    if (!(retired || halted)) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prog[3];
    int s, n, c0;

    vecs[0]  = '{"addi_x1",   32'h0010_7093, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h4,   32'h0};
    vecs[1]  = '{"add_x0",    32'h0010_0033, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h4,   32'h0};
    vecs[2]  = '{"sw",        32'h0000_2023, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h4,   32'h0};
    vecs[3]  = '{"beq_taken", 32'h0000_0063, 1'b1, 32'h40,  1'b0, 1'b0, 1'b0, 32'h40,  32'h40};
    vecs[4]  = '{"beq_mis",   32'h0000_0063, 1'b1, 32'h42,  1'b0, 1'b1, 1'b1, 32'h0,   32'hFFFF_FFFC};
    vecs[5]  = '{"beq_nt",    32'h0000_0063, 1'b0, 32'h42,  1'b0, 1'b0, 1'b0, 32'h4,   32'h0};
    vecs[6]  = '{"jal_x10",   32'h0000_056F, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h100, 32'h100};
    vecs[7]  = '{"jalr_x1",   32'h0000_00E7, 1'b1, 32'h80,  1'b1, 1'b0, 1'b0, 32'h80,  32'h80};
    vecs[8]  = '{"lui_x5",    32'h0000_12B7, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h4,   32'h0};
    vecs[9]  = '{"all_ones",  32'hFFFF_FFFF, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h0,   32'hFFFF_FFFC};
    vecs[10] = '{"ecall",     32'h0000_0073, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0,   32'hFFFF_FFFC};
    vecs[11] = '{"custom0",   32'h0000_000B, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h0,   32'hFFFF_FFFC};
    vecs[12] = '{"ebreak",    32'h0010_0073, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0,   32'hFFFF_FFFC};
    vecs[13] = '{"lw_x1",     32'h0000_2083, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h4,   32'h0};
    vecs[14] = '{"auipc_x2",  32'h0000_0117, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h4,   32'h0};

    // Reset state.
    do_reset();
    check("rst_imem_req", imem_req, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_word", instruction_word, 32'h0);
    check("rst_count", retire_count, 32'h0);
    check("rst_halted", halted, 32'd0);
    check("rst_illegal", illegal, 32'd0);
    check("rst_reg_we", reg_we, 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);

    // Straight-line program, zero-wait memory; run drops during the third.
    prog[0] = 32'h0010_7093;
    prog[1] = 32'h0010_7013;
    prog[2] = 32'h0010_0033;
    run = 1'b1;
    c0  = cyc;
    for (int k = 0; k < 3; k++) begin
      serve("sl", prog[k], 0, 0, 32'(k * 4), s);
      if (k == 2) run = 1'b0;
      wait_done(n);
      check("sl_retire_cycle", 32'(cyc - c0), 32'((k + 1) * 5));
      check("sl_reg_we", reg_we, (k == 0) ? 32'd1 : 32'd0);
    end
    step();
    check("sl_pc", pc, 32'h0C);
    check("sl_count", retire_count, 32'd3);
    check("sl_we_pulses", 32'(we_pulses), 32'd1);
    check("sl_ret_pulses", 32'(ret_pulses), 32'd3);
    check("sl_wrap_pc", w_pc, 32'h8);
    step();
    step();
    check("sl_idle_req", imem_req, 32'd0);

    // Memory stalls: ready delayed 3 cycles, rvalid delayed 2.
    run = 1'b1;
    serve("stall", 32'h0000_0013, 3, 2, 32'h0C, s);
    wait_done(n);
    check("stall_latency", 32'(s + n + 1), 32'd10);
    check("stall_retired", retired, 32'd1);

    // ECALL at a nonzero PC: halts cleanly with the PC left on it.
    serve("sys", 32'h0000_0073, 0, 0, 32'h10, s);
    wait_done(n);
    check("sys_halted", halted, 32'd1);
    check("sys_illegal", illegal, 32'd0);
    check("sys_pc", pc, 32'h10);
    check("sys_count", retire_count, 32'd4);
    step();
    step();
    step();
    check("sys_absorb_req", imem_req, 32'd0);
    check("sys_absorb_halt", halted, 32'd1);
    check("sys_ret_pulses", 32'(ret_pulses), 32'd4);

    // Reset asserted in WAIT, then a stale response with run low.
    do_reset();
    run = 1'b1;
    serve("pre", 32'h0010_7093, 0, 0, 32'h0, s);
    wait_done(n);
    begin
      bit ok;
      wait_req(ok);
    end
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    #2 rst = 1'b0;
    run = 1'b0;
    #1;
    check("wrst_imem_req", imem_req, 32'd0);
    check("wrst_pc", pc, 32'h0);
    check("wrst_word", instruction_word, 32'h0);
    check("wrst_count", retire_count, 32'h0);
    check("wrst_flags", {retired, reg_we, halted, illegal}, 32'h0);
    check("wrst_wrap_pc", w_pc, 32'hFFFF_FFFC);
    step();
    rst         = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hFFFF_FFFF;
    step();
    imem_rvalid = 1'b0;
    step();
    step();
    check("stale_word", instruction_word, 32'h0);
    check("stale_req", imem_req, 32'd0);
    check("stale_flags", {halted, illegal}, 32'h0);

    // Taken branch to 0x40, then an illegal word fetched from there.
    do_reset();
    run           = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    serve("br", 32'h0000_0063, 0, 0, 32'h0, s);
    wait_done(n);
    check("br_retired", retired, 32'd1);
    check("br_reg_we", reg_we, 32'd0);
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    serve("br_next", 32'hFFFF_FFFF, 0, 0, 32'h40, s);
    wait_done(n);
    check("ill_halted", halted, 32'd1);
    check("ill_illegal", illegal, 32'd1);
    check("ill_pc", pc, 32'h40);
    check("ill_count", retire_count, 32'd1);
    step();
    step();
    check("ill_ret_pulses", 32'(ret_pulses), 32'd1);
    check("ill_req", imem_req, 32'd0);

    // Single-instruction vectors from reset.
    for (int i = 0; i < 15; i++) begin
      do_reset();
      run           = 1'b1;
      branch_taken  = vecs[i].taken;
      branch_target = vecs[i].target;
      serve(vecs[i].name, vecs[i].word, 0, 0, 32'h0, s);
      wait_done(n);
      check({vecs[i].name, "_we"}, reg_we, 32'(vecs[i].exp_we));
      run = 1'b0;
      step();
      branch_taken = 1'b0;
      check({vecs[i].name, "_halted"}, halted, 32'(vecs[i].exp_halt));
      check({vecs[i].name, "_illegal"}, illegal, 32'(vecs[i].exp_ill));
      check({vecs[i].name, "_pc"}, pc, vecs[i].exp_pc);
      check({vecs[i].name, "_wrap_pc"}, w_pc, vecs[i].exp_wpc);
      check({vecs[i].name, "_count"}, retire_count, vecs[i].exp_halt ? 32'd0 : 32'd1);
      check({vecs[i].name, "_pulses"}, 32'(ret_pulses), vecs[i].exp_halt ? 32'd0 : 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
